// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - Run/Done sequencer for processador_multiciclo driven by a debounced step key
// Supports single-step, continuous and run-to-count operation with a Done watchdog.
module run_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int CNT_W           = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             StepKey,
    input  logic [1:0]       Mode,
    input  logic [CNT_W-1:0] Limit,
    input  logic             Done,
    output logic             Run,
    output logic             Busy,
    output logic             Halted,
    output logic             Timeout,
    output logic [CNT_W-1:0] InstrCount,
    output logic [2:0]       State
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TM_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_GAP       = 3'd3,
        S_HALT      = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              sync1;
    logic              sync2;
    logic              key_level;
    logic [DB_W-1:0]   db_cnt;
    logic              step_pulse;
    logic [TM_W-1:0]   timer;
    logic [CNT_W-1:0]  run_count;
    logic              stop_req;
    logic              stop_eff;

    // Key level only flips after a full run of disagreeing samples; a press emits one pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            key_level  <= 1'b1;
            db_cnt     <= '0;
            step_pulse <= 1'b0;
        end else begin
            sync1      <= StepKey;
            sync2      <= sync1;
            step_pulse <= 1'b0;
            if (sync2 != key_level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_level  <= sync2;
                    db_cnt     <= '0;
                    step_pulse <= key_level;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A press landing in GAP itself still counts as a stop request.
    assign stop_eff = stop_req | step_pulse;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (step_pulse) begin
                    case (Mode)
                        2'b01, 2'b10: next_state = S_ISSUE;
                        2'b11:        if (Limit != '0) next_state = S_ISSUE;
                        default:      next_state = S_IDLE;
                    endcase
                end
            end
            S_ISSUE:     next_state = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (Done) begin
                    next_state = S_GAP;
                end else if (timer == TM_W'(TIMEOUT_CYCLES - 1)) begin
                    next_state = S_FAULT;
                end
            end
            S_GAP: begin
                case (Mode)
                    2'b10:   next_state = stop_eff ? S_IDLE : S_ISSUE;
                    2'b11:   next_state = (run_count == Limit) ? S_HALT : S_ISSUE;
                    default: next_state = S_IDLE;
                endcase
            end
            S_HALT:  if (step_pulse) next_state = S_IDLE;
            S_FAULT: if (Mode == 2'b00) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            timer      <= '0;
            run_count  <= '0;
            stop_req   <= 1'b0;
            InstrCount <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (step_pulse && Mode == 2'b11 && Limit != '0) run_count <= '0;
                end
                S_ISSUE: timer <= '0;
                S_WAIT_DONE: begin
                    timer <= timer + 1'b1;
                    if (Done) begin
                        InstrCount <= InstrCount + 1'b1;
                        run_count  <= run_count + 1'b1;
                    end
                end
                S_HALT: begin
                    if (step_pulse) run_count <= '0;
                end
                default: ;
            endcase
            if (state == S_GAP) begin
                stop_req <= 1'b0;
            end else if (step_pulse && (state == S_ISSUE || state == S_WAIT_DONE)) begin
                stop_req <= 1'b1;
            end
        end
    end

    always_comb begin
        Run     = (state == S_ISSUE);
        Busy    = (state == S_ISSUE) || (state == S_WAIT_DONE) || (state == S_GAP);
        Halted  = (state == S_HALT);
        Timeout = (state == S_FAULT);
        State   = state;
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - scoreboard bench for run_sequencer with a randomized Done responder
module tb_run_sequencer;
    localparam int CW = 4;

    logic          clk;
    logic          Reset;
    logic          StepKey;
    logic [1:0]    Mode;
    logic [CW-1:0] Limit;
    logic          Done;
    logic          Run;
    logic          Busy;
    logic          Halted;
    logic          Timeout;
    logic [CW-1:0] InstrCount;
    logic [2:0]    State;

    int checks = 0;
    int errors = 0;
    int model_count = 0;
    int done_delay = 3;
    int resp_d;
    int run_total = 0;
    int dones_total = 0;
    int busy_cycles = 0;
    int wait_cycles = 0;
    int prev_state = 0;
    logic prev_run = 1'b0;
    int exp_q[$];
    int trace[$];

    run_sequencer #(.DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(64), .CNT_W(CW)) dut (
        .Clock(clk), .Reset(Reset), .StepKey(StepKey), .Mode(Mode), .Limit(Limit),
        .Done(Done), .Run(Run), .Busy(Busy), .Halted(Halted), .Timeout(Timeout),
        .InstrCount(InstrCount), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Processor stand-in: each Run is answered by one Done after the chosen delay.
    always @(negedge clk) begin
        if (Run && done_delay != -1) begin
            resp_d = (done_delay == 0) ? int'($urandom_range(1, 6)) : done_delay;
            repeat (resp_d) @(negedge clk);
            Done = 1'b1;
            model_count = (model_count + 1) % (1 << CW);
            exp_q.push_back(model_count);
            dones_total++;
            @(negedge clk);
            Done = 1'b0;
        end
    end

    // Monitor: each GAP is the DUT presenting a completed instruction.
    always @(negedge clk) begin
        if (!Reset) begin
            if (State == 3'd3) begin
                if (exp_q.size() == 0) check("gap_unexpected", 1, 0);
                else check("gap_count", int'(InstrCount), exp_q.pop_front());
            end
            if (Run) begin
                run_total++;
                check("run_one_cycle", int'(prev_run), 0);
            end
            if (Busy) busy_cycles++;
            if (State == 3'd2) wait_cycles++;
            if (int'(State) != prev_state) trace.push_back(int'(State));
        end
        prev_state = int'(State);
        prev_run = Run;
    end

    task automatic press();
        @(negedge clk);
        StepKey = 1'b0;
        repeat (20) @(negedge clk);
        StepKey = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    task automatic wait_state(input string name, input int s, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (int'(State) == s) break;
            @(negedge clk);
        end
        check(name, int'(State), s);
    endtask

    initial begin
        int runs0;
        int cnt0;
        int lim;
        int exp_tr[4];
        exp_tr = '{1, 2, 3, 0};
        Reset = 1'b1; StepKey = 1'b1; Mode = 2'b00; Limit = '0; Done = 1'b0;
        repeat (4) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        check("rst_state", int'(State), 0);
        check("rst_run", int'(Run), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_flags", int'({Halted, Timeout}), 0);
        check("rst_count", int'(InstrCount), 0);

        // Glitch shorter than the debounce window.
        Mode = 2'b01;
        StepKey = 1'b0;
        repeat (10) @(negedge clk);
        StepKey = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_run", run_total, 0);
        check("glitch_state", int'(State), 0);

        // Single step.
        done_delay = 3; busy_cycles = 0; trace.delete();
        press();
        wait_state("step_idle", 0, 50);
        check("step_runs", run_total, 1);
        check("step_busy", busy_cycles, 5);
        check("step_count", int'(InstrCount), model_count);
        check("step_trace_len", trace.size(), 4);
        for (int i = 0; i < 4; i++) if (i < trace.size()) check("step_trace", trace[i], exp_tr[i]);

        // Run-to-count, fixed then random.
        for (int k = 0; k < 2; k++) begin
            lim = (k == 0) ? 4 : int'($urandom_range(2, 6));
            done_delay = (k == 0) ? 2 : 0;
            Mode = 2'b11; Limit = CW'(lim);
            runs0 = run_total;
            press();
            wait_state("cnt_halt", 4, 200);
            check("cnt_runs", run_total - runs0, lim);
            check("cnt_halted", int'(Halted), 1);
            check("cnt_count", int'(InstrCount), model_count);
            press();
            wait_state("cnt_release", 0, 50);
            check("cnt_halted_clr", int'(Halted), 0);
        end

        // Limit of zero and idle mode ignore the key.
        Limit = '0; runs0 = run_total;
        press();
        Mode = 2'b00;
        press();
        check("ignored_runs", run_total - runs0, 0);
        check("ignored_state", int'(State), 0);

        // Continuous with a stop press.
        done_delay = 2; Mode = 2'b10; runs0 = run_total; cnt0 = dones_total;
        press();
        for (int i = 0; i < 200 && run_total - runs0 < 5; i++) @(negedge clk);
        press();
        wait_state("cont_idle", 0, 100);
        runs0 = run_total - runs0;
        repeat (40) @(negedge clk);
        check("cont_stopped", int'(State), 0);
        check("cont_runs_done", dones_total - cnt0, runs0);
        check("cont_min_runs", int'(runs0 > 5), 1);
        check("cont_count", int'(InstrCount), model_count);

        // Watchdog.
        done_delay = -1; Mode = 2'b01; wait_cycles = 0; cnt0 = model_count;
        press();
        wait_state("to_fault", 5, 150);
        check("to_flag", int'(Timeout), 1);
        check("to_wait_len", wait_cycles, 64);
        repeat (5) @(negedge clk);
        check("to_stays", int'(State), 5);
        Mode = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("to_exit", int'(State), 0);
        check("to_flag_clr", int'(Timeout), 0);
        check("to_count", int'(InstrCount), cnt0);

        // Bring the count to its top value, then wrap on a Done in the last watchdog cycle.
        lim = 15 - model_count;
        if (lim > 0) begin
            done_delay = 0; Mode = 2'b11; Limit = CW'(lim);
            press();
            wait_state("pre_halt", 4, 300);
            press();
            wait_state("pre_idle", 0, 50);
        end
        check("pre_top", int'(InstrCount), 15);
        done_delay = 64; Mode = 2'b01; wait_cycles = 0;
        press();
        wait_state("wrap_idle", 0, 150);
        check("wrap_zero", int'(InstrCount), 0);
        check("wrap_wait_len", wait_cycles, 64);
        check("wrap_no_fault", int'(Timeout), 0);

        repeat (10) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Board-side controller that sequences processador_multiciclo through its Run/Done handshake from one pushbutton and a mode selector.
- Debounces the step key, issues one-cycle Run pulses, waits for Done, and counts completed instructions.
- Supports single-step, continuous and run-to-count operation, with a Done watchdog.
- Sits in the top level between KEY/SW and the processor. Its count and state feed the HEX displays.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to change the debounced key level
TIMEOUT_CYCLES, 64, cycles allowed in WAIT_DONE before FAULT
CNT_W, 16, width of Limit and InstrCount

Ports:
Clock  in  1  single system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
StepKey  in  1  raw pushbutton, active-low (pressed = 0), asynchronous to Clock
Mode  in  2  00 idle, 01 single-step, 10 continuous, 11 run-to-count
Limit  in  CNT_W  instruction count for mode 11
Done  in  1  processor instruction-complete strobe
Run  out  1  one-cycle start pulse to processor
Busy  out  1  high in ISSUE, WAIT_DONE, GAP
Halted  out  1  high in HALT
Timeout  out  1  high in FAULT
InstrCount  out  CNT_W  total completed instructions, wraps
State  out  3  IDLE=0 ISSUE=1 WAIT_DONE=2 GAP=3 HALT=4 FAULT=5

Behaviour:
- Reset: State=IDLE; Run, Busy, Halted, Timeout=0; InstrCount=0; internal run_count=0; stop_req=0; timer=0. Sync flops and debounced level=1 (released); debounce counter=0.
- Debounce: StepKey passes 2-FF synchronizer. If the synced value differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles, the debounced level flips; any mismatch-free cycle clears the counter. step_pulse is a one cycle high on the debounced 1->0 transition only. Release generates nothing.
- IDLE: Run=0.
  - step_pulse with Mode 01 or 10 -> ISSUE.
  - Mode 11 and Limit!=0 -> ISSUE, with run_count cleared.
  - Mode 11 and Limit==0: pulse ignored.
  - Mode 00: ignored.
  - Done in IDLE is ignored.
- ISSUE: Run=1 for exactly this one cycle; timer cleared -> WAIT_DONE. Latency from step_pulse to Run high = 1 cycle.
- WAIT_DONE: Run=0; timer increments.
  - Done=1 -> InstrCount+1 (0xFFFF->0 for CNT_W=16), run_count+1, -> GAP.
  - Done=0 and timer==TIMEOUT_CYCLES-1 -> FAULT.
  - Done in that same cycle wins over timeout.
- GAP: one cycle; Mode is sampled here.
  - 01 -> IDLE.
  - 00 -> IDLE.
  - 10 -> IDLE if stop_req, else ISSUE.
  - 11 -> HALT if run_count==Limit, else ISSUE.
  - stop_req cleared on leaving GAP.
- Stop request: a step_pulse during ISSUE, WAIT_DONE or GAP sets stop_req. It only acts in Mode 10. An in-flight instruction always completes; Mode changes never abort it.
- HALT: Halted=1; step_pulse -> IDLE, clearing run_count. Mode is ignored.
- FAULT: Timeout=1; leaves only on Reset or Mode==00 -> IDLE. InstrCount is unchanged.
- Reset mid-operation overrides all states on the next edge, with the same values as reset. A Done arriving in the reset cycle is not counted.

Test Plan:
- Reset, StepKey held 1, DEBOUNCE_CYCLES=16 -> no Run, State=0, InstrCount=0. A 10-cycle glitch to 0 -> no step_pulse, no Run.
- Mode=01, key held 0 for 20 cycles, Done returned 3 cycles after Run -> exactly one Run pulse; InstrCount=1; State 1->2->3->0; Busy high 5 cycles.
- Mode=11, Limit=4, Done 2 cycles after each Run -> 4 Run pulses, InstrCount=4, Halted=1. A subsequent press -> IDLE, Halted=0.
- Mode=10, Done every 2 cycles, second press after 5 instructions -> the current instruction finishes. Then State=0 and no further Run; InstrCount = completed count.
- Mode=01, Done never asserted -> State=5, Timeout=1 after 64 cycles in WAIT_DONE. Mode=00 -> IDLE, Timeout=0, InstrCount unchanged.
- Preload via 0xFFFF completed instructions (or CNT_W=4 with 15 instructions), then one more -> InstrCount wraps to 0. Done coincident with the final timeout cycle -> counted, GAP entered, no FAULT.
